i2c_sensor_responder: RTL and testbench

- Synthesizable I2C target (slave) that answers the i2c_control master, as a stand-in for the temperature and lux sensors.
- Receives SCL and SDA and drives SDA through an open-drain enable.
- Serves a 16-bit live sensor word and a writable 16-bit config register, selected by a pointer byte.
- Used in FPGA loopback builds and as a synthesizable bench partner for i2c_control.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_bus_sync.sv | 81 ++++++++
 rtl/i2c_sensor_responder.sv | 189 ++++++++++++++++++
 tb/tb_i2c_sensor_responder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the i2c_sensor_responder slice: state encoding,
// register pointers, ACK levels and the write/read byte-index step.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK
  } state_t;

  localparam logic [7:0] PTR_DATA = 8'h00;
  localparam logic [7:0] PTR_CFG  = 8'h01;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Byte index saturates near 255 but keeps alternating parity, so MSB/LSB pairing survives.
  function automatic logic [7:0] next_idx(input logic [7:0] idx);
    return (idx == 8'hFF) ? 8'hFE : idx + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA conditioning: 2-FF synchronizers, optional 3-sample majority filter
// (I2C_GLITCH_FILTER_EN), and single-cycle edge / START / STOP strobes.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_lvl;
  logic       sda_lvl;
  logic       scl_hist;
  logic       sda_hist;

  // NOTE: synchronizers reset to 1 (idle bus level) so reset release never fakes an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_win;
  logic [1:0] sda_win;
  logic       scl_filt;
  logic       sda_filt;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_win  <= 2'b11;
      sda_win  <= 2'b11;
      scl_filt <= 1'b1;
      sda_filt <= 1'b1;
    end else begin
      scl_win  <= {scl_win[0], scl_sync[1]};
      sda_win  <= {sda_win[0], sda_sync[1]};
      scl_filt <= maj3({scl_win, scl_sync[1]});
      sda_filt <= maj3({sda_win, sda_sync[1]});
    end
  end

  assign scl_lvl = scl_filt;
  assign sda_lvl = sda_filt;
`else
  assign scl_lvl = scl_sync[1];
  assign sda_lvl = sda_sync[1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_hist <= scl_lvl;
      sda_hist <= sda_lvl;
    end
  end

  assign sda       = sda_lvl;
  assign scl_rise  = scl_lvl & ~scl_hist;
  assign scl_fall  = ~scl_lvl & scl_hist;
  // SCL must be high on both samples so an SDA change right after an SCL edge is not a condition.
  assign start_det = scl_lvl & scl_hist & ~sda_lvl & sda_hist;
  assign stop_det  = scl_lvl & scl_hist & sda_lvl & ~sda_hist;

endmodule

// File: rtl/i2c_sensor_responder.sv
// I2C target standing in for a sensor: register 0 = live sensor word, register 1 = config.
// Build option I2C_GLITCH_FILTER_EN adds a majority glitch filter on SCL/SDA.
module i2c_sensor_responder #(
  parameter logic [6:0]        ADDR    = 7'h48,
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] CFG_RST = 16'h60A0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic [DATA_W-1:0] sensor_data,
  output logic [DATA_W-1:0] cfg_reg,
  output logic [7:0]        reg_ptr,
  output logic              busy,
  output logic              rd_done,
  output logic              wr_done
);

  // Imported after the ADDR parameter; the address state is always named i2c_pkg::ADDR.
  import i2c_pkg::*;

  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_reg;
  logic [7:0]        byte_idx;
  logic [7:0]        msb_hold;
  logic [DATA_W-1:0] snapshot;
  logic [DATA_W-1:0] sel_word;
  logic [7:0]        cur_byte;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sel_word = '0;
    if (reg_ptr == PTR_DATA)     sel_word = sensor_data;
    else if (reg_ptr == PTR_CFG) sel_word = cfg_reg;
    cur_byte = byte_idx[0] ? snapshot[7:0] : snapshot[15:8];
  end

  // NOTE: sequential state uses <= so every flop sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      byte_idx  <= 8'h00;
      msb_hold  <= 8'h00;
      snapshot  <= '0;
      sda_oe    <= 1'b0;
      cfg_reg   <= CFG_RST;
      reg_ptr   <= PTR_DATA;
      busy      <= 1'b0;
      rd_done   <= 1'b0;
      wr_done   <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      wr_done <= 1'b0;
      if (start_det) begin
        state   <= i2c_pkg::ADDR;
        bit_cnt <= 3'd0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: sda_oe <= 1'b0;

          i2c_pkg::ADDR: begin
            if (scl_rise) begin
              shift_reg <= {shift_reg[6:0], sda};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (shift_reg[6:0] == ADDR) begin
                  state <= ADDR_ACK;
                  busy  <= 1'b1;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end
            end
          end

          // First SCL fall asserts ACK, the second ends it and starts the data phase.
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                byte_idx <= 8'h00;
                bit_cnt  <= 3'd0;
                if (shift_reg[0]) begin
                  snapshot <= sel_word;
                  sda_oe   <= ~sel_word[15];
                  state    <= RD_BYTE;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= WR_BYTE;
                end
              end
            end
          end

          WR_BYTE: begin
            if (scl_rise) begin
              shift_reg <= {shift_reg[6:0], sda};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= WR_ACK;
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
                if (byte_idx == 8'h00) begin
                  reg_ptr <= shift_reg;
                end else if (reg_ptr == PTR_CFG) begin
                  if (byte_idx[0]) begin
                    msb_hold <= shift_reg;
                  end else begin
                    cfg_reg <= {msb_hold, shift_reg};
                    wr_done <= 1'b1;
                  end
                end
              end else begin
                sda_oe   <= 1'b0;
                byte_idx <= next_idx(byte_idx);
                state    <= WR_BYTE;
              end
            end
          end

          // bit_cnt counts SCL rises, so on each fall it already points at the next bit to drive.
          RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= RD_ACK;
            end else if (scl_fall) begin
              sda_oe <= ~cur_byte[3'd7 - bit_cnt];
            end
          end

          RD_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
            end else if (scl_rise) begin
              rd_done <= 1'b1;
              if (sda == ACK) begin
                byte_idx <= next_idx(byte_idx);
                state    <= RD_BYTE;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end

          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_sensor_responder.sv
// Self-checking bench for i2c_sensor_responder: a bit-level I2C master plus a
// transaction-level register model (pointer, config word, two-byte read pattern).
`timescale 1ns/1ps
module tb_i2c_sensor_responder;

  localparam int Q = 100;  // quarter SCL period in ns (SCL = 2.5 MHz, clk = 100 MHz)
  localparam logic [6:0]  DEV    = 7'h48;
  localparam logic [15:0] CFG_RV = 16'h60A0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic [15:0] sensor_data = 16'h0000;
  logic        sda_oe;
  logic [15:0] cfg_reg;
  logic [7:0]  reg_ptr;
  logic        busy;
  logic        rd_done;
  logic        wr_done;
  logic        sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_sensor_responder dut (
    .clk         (clk),
    .rst         (rst),
    .scl_in      (scl_m),
    .sda_in      (sda_bus),
    .sda_oe      (sda_oe),
    .sensor_data (sensor_data),
    .cfg_reg     (cfg_reg),
    .reg_ptr     (reg_ptr),
    .busy        (busy),
    .rd_done     (rd_done),
    .wr_done     (wr_done)
  );

  always #5 clk = ~clk;

  int rd_cnt = 0;
  int wr_cnt = 0;
  int oe_cnt = 0;
  always @(negedge clk) begin
    if (rd_done) rd_cnt++;
    if (wr_done) wr_cnt++;
    if (sda_oe)  oe_cnt++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level register model.
  logic [15:0] m_cfg = CFG_RV;
  logic [7:0]  m_ptr = 8'h00;
  logic [7:0]  m_msb = 8'h00;

  function automatic logic [15:0] model_word(input logic [15:0] sens);
    if (m_ptr == 8'h00) return sens;
    if (m_ptr == 8'h01) return m_cfg;
    return 16'h0000;
  endfunction

  // ---------------- bit-level master ----------------
  task automatic bit_xfer(input logic b, output logic r);
    sda_m = b;  #Q;
    scl_m = 1'b1; #Q;
    r = sda_bus; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic last, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(1'b1, d[i]);
    bit_xfer(last, r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    logic        ack;
    logic [7:0]  d;
    logic [7:0]  b;
    logic [15:0] v;
    int          n;
    int          len;
    int          base_rd;
    int          base_wr;
    int          base_oe;

    // ---- reset state ----
    sensor_data = 16'h1A50;
    repeat (5) @(posedge clk);
    #1;
    check("rst_sda_oe",  32'(sda_oe),  32'(1'b0));
    check("rst_cfg",     32'(cfg_reg), 32'(CFG_RV));
    check("rst_ptr",     32'(reg_ptr), 32'(8'h00));
    check("rst_busy",    32'(busy),    32'(1'b0));
    check("rst_rd_done", 32'(rd_done), 32'(1'b0));
    check("rst_wr_done", 32'(wr_done), 32'(1'b0));
    rst = 1'b1;
    #(Q);

    // ---- read 0x48, ptr 0, ACK then NACK ----
    base_rd = rd_cnt;
    i2c_start;
    write_byte({DEV, 1'b1}, ack);
    check("rd_addr_ack", 32'(ack), 32'(1'b0));
    check("rd_busy", 32'(busy), 32'(1'b1));
    read_byte(1'b0, d);
    check("rd_byte0", 32'(d), 32'(8'h1A));
    read_byte(1'b1, d);
    check("rd_byte1", 32'(d), 32'(8'h50));
    i2c_stop;
    check("rd_done_count", 32'(rd_cnt - base_rd), 32'(2));
    check("rd_busy_after_stop", 32'(busy), 32'(1'b0));

    // ---- write ptr 1, 0xBE 0xEF ----
    base_wr = wr_cnt;
    i2c_start;
    write_byte({DEV, 1'b0}, ack); check("wr_addr_ack", 32'(ack), 32'(1'b0));
    write_byte(8'h01, ack);       check("wr_ptr_ack",  32'(ack), 32'(1'b0));
    write_byte(8'hBE, ack);       check("wr_msb_ack",  32'(ack), 32'(1'b0));
    check("wr_no_early_done", 32'(wr_cnt - base_wr), 32'(0));
    write_byte(8'hEF, ack);       check("wr_lsb_ack",  32'(ack), 32'(1'b0));
    i2c_stop;
    m_ptr = 8'h01; m_cfg = 16'hBEEF;
    check("wr_cfg", 32'(cfg_reg), 32'(m_cfg));
    check("wr_ptr", 32'(reg_ptr), 32'(m_ptr));
    check("wr_done_count", 32'(wr_cnt - base_wr), 32'(1));

    // ---- wrong address 0x49 ----
    base_oe = oe_cnt;
    i2c_start;
    write_byte({7'h49, 1'b0}, ack);
    check("bad_addr_nack", 32'(ack), 32'(1'b1));
    check("bad_addr_busy", 32'(busy), 32'(1'b0));
    i2c_stop;
    check("bad_addr_no_drive", 32'(oe_cnt - base_oe), 32'(0));
    check("bad_addr_cfg", 32'(cfg_reg), 32'(m_cfg));

    // ---- ptr 0, repeated start, read with sensor_data changing mid-read ----
    sensor_data = 16'hC3A5;
    i2c_start;
    write_byte({DEV, 1'b0}, ack); check("rs_addr_ack", 32'(ack), 32'(1'b0));
    write_byte(8'h00, ack);       check("rs_ptr_ack",  32'(ack), 32'(1'b0));
    m_ptr = 8'h00;
    i2c_start;
    write_byte({DEV, 1'b1}, ack); check("rs_rd_ack", 32'(ack), 32'(1'b0));
    sensor_data = 16'h5A3C;
    read_byte(1'b0, d);           check("rs_snap_msb", 32'(d), 32'(8'hC3));
    sensor_data = 16'h0F0F;
    read_byte(1'b0, d);           check("rs_snap_lsb", 32'(d), 32'(8'hA5));
    read_byte(1'b1, d);           check("rs_repeat_msb", 32'(d), 32'(8'hC3));
    i2c_stop;

    // ---- randomized write-then-read transactions ----
    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 3))
        0: b = 8'h00;
        1, 2: b = 8'h01;
        default: b = 8'(2 + $urandom_range(0, 253));
      endcase
      n = $urandom_range(0, 4);
      base_wr = wr_cnt;
      i2c_start;
      write_byte({DEV, 1'b0}, ack); check("rnd_wr_addr_ack", 32'(ack), 32'(1'b0));
      write_byte(b, ack);           check("rnd_wr_ptr_ack",  32'(ack), 32'(1'b0));
      m_ptr = b;
      len = 0;  // expected wr_done pulses
      for (int k = 1; k <= n; k++) begin
        d = 8'($urandom);
        write_byte(d, ack);
        check("rnd_wr_data_ack", 32'(ack), 32'(1'b0));
        if (m_ptr == 8'h01) begin
          if (k % 2 == 1) m_msb = d;
          else begin m_cfg = {m_msb, d}; len++; end
        end
      end
      check("rnd_wr_done_count", 32'(wr_cnt - base_wr), 32'(len));
      check("rnd_cfg", 32'(cfg_reg), 32'(m_cfg));
      check("rnd_ptr", 32'(reg_ptr), 32'(m_ptr));
      if ($urandom_range(0, 3) != 0) begin
        sensor_data = 16'($urandom);
        v = model_word(sensor_data);
        len = $urandom_range(1, 4);
        base_rd = rd_cnt;
        i2c_start;
        write_byte({DEV, 1'b1}, ack); check("rnd_rd_addr_ack", 32'(ack), 32'(1'b0));
        sensor_data = 16'($urandom);
        for (int k = 0; k < len; k++) begin
          read_byte(k == len - 1, d);
          check("rnd_rd_byte", 32'(d), 32'((k % 2 == 0) ? v[15:8] : v[7:0]));
        end
        check("rnd_rd_done_count", 32'(rd_cnt - base_rd), 32'(len));
      end
      i2c_stop;
      check("rnd_busy_idle", 32'(busy), 32'(1'b0));
    end

    // ---- reset during the second read byte ----
    i2c_start;
    write_byte({DEV, 1'b0}, ack);
    write_byte(8'h01, ack);
    write_byte(8'h12, ack);
    write_byte(8'h34, ack);
    i2c_stop;
    check("pre_rst_cfg", 32'(cfg_reg), 32'(16'h1234));
    sensor_data = 16'h5A00;
    i2c_start;
    write_byte({DEV, 1'b0}, ack);
    write_byte(8'h00, ack);
    i2c_start;
    write_byte({DEV, 1'b1}, ack);
    read_byte(1'b0, d);
    check("pre_rst_byte0", 32'(d), 32'(8'h5A));
    bit_xfer(1'b1, ack);
    bit_xfer(1'b1, ack);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #(Q / 2);
    check("pre_rst_driving", 32'(sda_oe), 32'(1'b1));
    rst = 1'b0;
    #1;
    check("mid_rst_sda_oe", 32'(sda_oe),  32'(1'b0));
    check("mid_rst_cfg",    32'(cfg_reg), 32'(CFG_RV));
    check("mid_rst_busy",   32'(busy),    32'(1'b0));
    check("mid_rst_ptr",    32'(reg_ptr), 32'(8'h00));
    #50;
    rst = 1'b1;
    m_cfg = CFG_RV;
    m_ptr = 8'h00;
    #(Q);
    sensor_data = 16'($urandom);
    v = model_word(sensor_data);
    i2c_start;
    write_byte({DEV, 1'b1}, ack); check("post_rst_addr_ack", 32'(ack), 32'(1'b0));
    read_byte(1'b0, d);           check("post_rst_msb", 32'(d), 32'(v[15:8]));
    read_byte(1'b1, d);           check("post_rst_lsb", 32'(d), 32'(v[7:0]));
    i2c_stop;

`ifdef I2C_GLITCH_FILTER_EN
    // ---- one-cycle SDA glitch with SCL high must not count as START ----
    #(Q);
    base_oe = oe_cnt;
    @(negedge clk) sda_m = 1'b0;
    @(negedge clk) sda_m = 1'b1;
    #(Q);
    scl_m = 1'b0; #(Q);
    write_byte({DEV, 1'b0}, ack);
    check("glitch_no_ack", 32'(ack), 32'(1'b1));
    check("glitch_busy", 32'(busy), 32'(1'b0));
    check("glitch_no_drive", 32'(oe_cnt - base_oe), 32'(0));
    i2c_stop;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
